// File: rtl/uart_rx_frame_check.sv
// uart_rx_frame_check
// Clocked UART receive frame checker. Takes one majority-voted bit per strobe
// from the RX sampler, deserialises LSB-first data, checks parity (even, odd,
// mark, space or none) and one or two stop bits. It reports per-frame error
// flags and keeps saturating error counters.
//
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous active-low reset
//   PAR_EN       parity bit present (latched on frame_start)
//   PAR_TYP      00 even, 01 odd, 10 mark, 11 space (latched on frame_start)
//   STOP_BITS    0 = one stop bit, 1 = two (latched on frame_start)
//   frame_start  validated start bit; restarts the frame from any state
//   bit_strb     sampled_bit is valid this cycle
//   sampled_bit  received bit value
//   err_clr      synchronous clear of both error counters
//   P_data       received data, bit 0 = first data bit received
//   data_valid   one-cycle pulse at frame completion
//   par_err      parity error of the last completed frame
//   stp_err      stop error of the last completed frame
//   busy         frame in progress
//   par_err_cnt  saturating count of frames with par_err
//   stp_err_cnt  saturating count of frames with stp_err
module uart_rx_frame_check #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  STOP_BITS,
  input  logic                  frame_start,
  input  logic                  bit_strb,
  input  logic                  sampled_bit,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] P_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0]        BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0]        BIT_ONE  = BW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    xor_q, xor_d;
  logic                    par_mis_q, par_mis_d;
  logic                    stp_acc_q, stp_acc_d;
  logic                    par_en_q, par_en_d;
  logic [1:0]              par_typ_q, par_typ_d;
  logic                    stop_bits_q, stop_bits_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;
  logic [CNT_WIDTH-1:0]    par_cnt_q, par_cnt_d;
  logic [CNT_WIDTH-1:0]    stp_cnt_q, stp_cnt_d;
  logic                    par_exp;
  logic                    finish;

  // Expected parity bit for the latched mode.
  always_comb begin
    par_exp = 1'b0;
    case (par_typ_q)
      2'b00:   par_exp = xor_q;
      2'b01:   par_exp = ~xor_q;
      2'b10:   par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    xor_d       = xor_q;
    par_mis_d   = par_mis_q;
    stp_acc_d   = stp_acc_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    stop_bits_d = stop_bits_q;
    p_data_d    = p_data_q;
    par_err_d   = par_err_q;
    stp_err_d   = stp_err_q;
    par_cnt_d   = par_cnt_q;
    stp_cnt_d   = stp_cnt_q;
    finish      = 1'b0;

    if (frame_start) begin
      // Start (or abort and restart) a frame; any same-cycle strobe is dropped.
      state_d     = DATA;
      bit_cnt_d   = '0;
      xor_d       = 1'b0;
      par_mis_d   = 1'b0;
      stp_acc_d   = 1'b0;
      par_en_d    = PAR_EN;
      par_typ_d   = PAR_TYP;
      stop_bits_d = STOP_BITS;
    end else begin
      case (state_q)
        DATA: begin
          if (bit_strb) begin
            shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
            xor_d     = xor_q ^ sampled_bit;
            bit_cnt_d = bit_cnt_q + BIT_ONE;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = par_en_q ? PARITY : STOP1;
            end
          end
        end
        PARITY: begin
          if (bit_strb) begin
            par_mis_d = (sampled_bit != par_exp);
            state_d   = STOP1;
          end
        end
        STOP1: begin
          if (bit_strb) begin
            stp_acc_d = stp_acc_q | ~sampled_bit;
            if (stop_bits_q) begin
              state_d = STOP2;
            end else begin
              finish = 1'b1;
            end
          end
        end
        STOP2: begin
          if (bit_strb) begin
            stp_acc_d = stp_acc_q | ~sampled_bit;
            finish    = 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
          if (par_err_q && (par_cnt_q != '1)) par_cnt_d = par_cnt_q + CNT_ONE;
          if (stp_err_q && (stp_cnt_q != '1)) stp_cnt_d = stp_cnt_q + CNT_ONE;
        end
        default: ;
      endcase
    end

    // Results are registered on the last stop strobe so that they are
    // visible together with data_valid while the FSM sits in DONE.
    if (finish) begin
      state_d   = DONE;
      p_data_d  = shift_q;
      par_err_d = par_en_q & par_mis_q;
      stp_err_d = stp_acc_q | ~sampled_bit;
    end

    if (err_clr) begin
      par_cnt_d = '0;
      stp_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      xor_q       <= 1'b0;
      par_mis_q   <= 1'b0;
      stp_acc_q   <= 1'b0;
      par_en_q    <= 1'b0;
      par_typ_q   <= '0;
      stop_bits_q <= 1'b0;
      p_data_q    <= '0;
      par_err_q   <= 1'b0;
      stp_err_q   <= 1'b0;
      par_cnt_q   <= '0;
      stp_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      xor_q       <= xor_d;
      par_mis_q   <= par_mis_d;
      stp_acc_q   <= stp_acc_d;
      par_en_q    <= par_en_d;
      par_typ_q   <= par_typ_d;
      stop_bits_q <= stop_bits_d;
      p_data_q    <= p_data_d;
      par_err_q   <= par_err_d;
      stp_err_q   <= stp_err_d;
      par_cnt_q   <= par_cnt_d;
      stp_cnt_q   <= stp_cnt_d;
    end
  end

  assign P_data      = p_data_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign data_valid  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign par_err_cnt = par_cnt_q;
  assign stp_err_cnt = stp_cnt_q;

endmodule
